poly_op_sequencer: RTL and testbench
====================================

// Module: poly_op_sequencer
// PURPOSE
//  Parametrised control sequencer for the polynomial arithmetic unit: runs NTT, INTT, pointwise multiply (MULT)
//  and add/sub (ADDSUB) over one polynomial stored as WORDS memory words. Drives memory read/write addresses and
//  enables plus butterfly-datapath controls (stage/type/pre_load/load). Adds over the previous controller:
//  start/busy/done handshake, latched configuration, abort, parametrised datapath latency and inter-pass RAW drain.
// PARAMETERS
//  ADDR_W      8   memory address width; all address sums wrap mod 2^ADDR_W
//  WORDS       32  memory words per polynomial (>=2)
//  NTT_PASSES  7   passes per NTT/INTT (1..8; dp_stage is 3 bits)
//  DP_LAT      3   cycles from issue of a result-producing read to its write (>=1)
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       request; accepted only in IDLE
//  mode        in   2       0 NTT, 1 INTT, 2 MULT, 3 ADDSUB; latched at start
//  add_or_sub  in   1       ADDSUB select (0 add, 1 sub); latched at start
//  a_base      in   ADDR_W  operand A base address; latched at start
//  b_base      in   ADDR_W  operand B base address; latched at start
//  w_base      in   ADDR_W  result base address; latched at start
//  abort       in   1       cancel running operation
//  rd_en       out  1       memory read strobe
//  rd_addr     out  ADDR_W  memory read address
//  wr_en       out  1       memory write strobe (write data comes from the datapath)
//  wr_addr     out  ADDR_W  memory write address
//  dp_mode     out  2       latched mode to datapath
//  dp_stage    out  3       datapath stage
//  dp_type     out  1       datapath type bit
//  dp_pre_load out  1       datapath captures operand A
//  dp_load     out  1       datapath captures operand B
//  busy        out  1       operation in progress
//  done        out  1       one-cycle completion pulse
// BEHAVIOUR
//  Reset: state IDLE; every output 0; latched config 0; write pipeline cleared.
//  FSM: IDLE -> ISSUE (start=1) -> DRAIN -> (next NTT pass: ISSUE | last: DONE) -> IDLE. DONE lasts 1 cycle.
//   Cycle 0 = start sampled in IDLE. busy=1 in ISSUE/DRAIN; busy=0, done=1 in DONE. start ignored outside IDLE.
//  Write pipe: DP_LAT-deep shift reg of {valid, addr}; a result-producing issue at cycle t -> wr_en=1 at t+DP_LAT.
//  ADDSUB: issue cycles 1..2*WORDS, word i: cycle 2i+1 reads a_base+i (dp_pre_load=1, dp_stage=0);
//   cycle 2i+2 reads b_base+i (dp_load=1, dp_stage=1, result-producing, write to w_base+i). dp_type=add_or_sub.
//  MULT: 4 cycles/word, phase ph=0..3 from cycle 4i+1. ph0 reads a_base+i (pre_load), ph1 reads b_base+i (load),
//   ph2/ph3 rd_en=0. dp_stage={0,ph}, dp_type=ph[0]. ph3 is result-producing (write w_base+i).
//  NTT/INTT: pass p=0..NTT_PASSES-1, WORDS issue cycles, word j reads (p==0 ? a_base : w_base)+j, every issue
//   result-producing, writes w_base+j; dp_stage=p, dp_type=j[0]. Pass p+1 starts only after DRAIN.
//  DRAIN: exactly DP_LAT cycles after the last issue of a pass; final write lands in last DRAIN cycle, so next
//   pass's first read follows last write by 1 cycle (no RAW hazard). rd_en=0 and dp_pre_load/dp_load=0 in DRAIN.
//  Totals (done cycle): ADDSUB 2*WORDS+DP_LAT+1; MULT 4*WORDS+DP_LAT+1; NTT/INTT NTT_PASSES*(WORDS+DP_LAT)+1.
//  rd_addr/wr_addr = 0 when their enable is 0. dp_* = 0 outside ISSUE/DRAIN except dp_mode (holds latch).
//  abort (ISSUE/DRAIN): next cycle IDLE, write pipe flushed, wr_en=0 from that cycle, no done. Ignored in IDLE/DONE.
//  abort and start same cycle in IDLE: start wins. rst mid-operation: identical to reset, no done, no writes.
// TESTING
//  Defaults. ADDSUB a=0x10 b=0x40 w=0x80: rd_addr 0x10@1, 0x40@2; wr_en@5 addr 0x80; last wr 0x9F@67; done@68.
//  MULT a=0 b=0x20 w=0x40: rd_en@1,2 not @3,4; writes 0x40@7, 0x41@11; done@132, busy low @132.
//  NTT a=0x00 w=0x20: pass0 reads 0x00..0x1F @1..32; no rd_en @33..35; pass1 reads 0x20@36, dp_stage=1; done@246.
//  start pulsed @10 during ADDSUB -> ignored, done still @68; start held high -> next op starts @69 (IDLE).
//  abort @100 in NTT pass 2 -> @101 busy=0, wr_en=0, no done ever; rst @50 same response.
//  ADDSUB w=0xF0: wr_addr 0xFF for i=15 then 0x00 for i=16 (wrap), done@68.

Source files
------------

// File: rtl/poly_op_sequencer.sv
// Control sequencer for the polynomial arithmetic unit: issues memory reads, tracks in-flight results
// through a DP_LAT-deep write pipe and steers the butterfly datapath for NTT/INTT, MULT and ADDSUB.
module poly_op_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int WORDS      = 32,
  parameter int NTT_PASSES = 7,
  parameter int DP_LAT     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              add_or_sub,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        dp_mode,
  output logic [2:0]        dp_stage,
  output logic              dp_type,
  output logic              dp_pre_load,
  output logic              dp_load,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [1:0] M_MULT   = 2'd2;
  localparam logic [1:0] M_ADDSUB = 2'd3;
  localparam int CNT_W = $clog2(4 * WORDS);
  localparam int DRN_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DRN_W-1:0]  drn;
  logic [2:0]        pass_q;
  logic [1:0]        mode_q;
  logic              aos_q;
  logic [ADDR_W-1:0] a_q, b_q, w_q;
  logic              pipe_v [DP_LAT];
  logic [ADDR_W-1:0] pipe_a [DP_LAT];

  logic              issue_last, drain_last, pass_last, is_ntt;
  logic              issue_res;
  logic [ADDR_W-1:0] issue_waddr;

  assign is_ntt     = !mode_q[1];
  assign drain_last = (drn == DRN_W'(DP_LAT - 1));
  assign pass_last  = (pass_q == 3'(NTT_PASSES - 1));

  // NOTE: every combinational output is given a default before the case so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    issue_last  = 1'b0;
    issue_res   = 1'b0;
    issue_waddr = '0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    dp_stage    = '0;
    dp_type     = 1'b0;
    dp_pre_load = 1'b0;
    dp_load     = 1'b0;
    busy        = (state == S_ISSUE) || (state == S_DRAIN);
    done        = (state == S_DONE);
    dp_mode     = mode_q;

    case (mode_q)
      M_ADDSUB: issue_last = (cnt == CNT_W'(2 * WORDS - 1));
      M_MULT:   issue_last = (cnt == CNT_W'(4 * WORDS - 1));
      default:  issue_last = (cnt == CNT_W'(WORDS - 1));
    endcase

    if (state == S_ISSUE) begin
      case (mode_q)
        M_ADDSUB: begin
          // Even counts fetch operand A, odd counts fetch B and produce the result.
          rd_en       = 1'b1;
          rd_addr     = (cnt[0] ? b_q : a_q) + ADDR_W'(cnt >> 1);
          dp_pre_load = !cnt[0];
          dp_load     = cnt[0];
          dp_stage    = {2'b00, cnt[0]};
          dp_type     = aos_q;
          issue_res   = cnt[0];
          issue_waddr = w_q + ADDR_W'(cnt >> 1);
        end
        M_MULT: begin
          rd_en       = !cnt[1];
          rd_addr     = cnt[1] ? '0 : (cnt[0] ? b_q : a_q) + ADDR_W'(cnt >> 2);
          dp_pre_load = (cnt[1:0] == 2'd0);
          dp_load     = (cnt[1:0] == 2'd1);
          dp_stage    = {1'b0, cnt[1:0]};
          dp_type     = cnt[0];
          issue_res   = (cnt[1:0] == 2'd3);
          issue_waddr = w_q + ADDR_W'(cnt >> 2);
        end
        default: begin
          rd_en       = 1'b1;
          rd_addr     = ((pass_q == '0) ? a_q : w_q) + ADDR_W'(cnt);
          dp_stage    = pass_q;
          dp_type     = cnt[0];
          issue_res   = 1'b1;
          issue_waddr = w_q + ADDR_W'(cnt);
        end
      endcase
    end else if (state == S_DRAIN && is_ntt) begin
      dp_stage = pass_q;
    end

    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (abort) state_nxt = S_IDLE;
               else if (issue_last) state_nxt = S_DRAIN;
      S_DRAIN: if (abort) state_nxt = S_IDLE;
               else if (drain_last) state_nxt = (is_ntt && !pass_last) ? S_ISSUE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign wr_en   = pipe_v[DP_LAT-1];
  assign wr_addr = pipe_v[DP_LAT-1] ? pipe_a[DP_LAT-1] : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      drn    <= '0;
      pass_q <= '0;
      mode_q <= '0;
      aos_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      w_q    <= '0;
      // NOTE: the write pipe is a handful of flops, not a RAM, so it is cleared here; a stale valid would fire a spurious write.
      for (int k = 0; k < DP_LAT; k++) begin
        pipe_v[k] <= 1'b0;
        pipe_a[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          cnt    <= '0;
          drn    <= '0;
          pass_q <= '0;
          mode_q <= mode;
          aos_q  <= add_or_sub;
          a_q    <= a_base;
          b_q    <= b_base;
          w_q    <= w_base;
        end
        S_ISSUE: cnt <= issue_last ? '0 : cnt + 1'b1;
        S_DRAIN: begin
          drn <= drain_last ? '0 : drn + 1'b1;
          if (drain_last) pass_q <= pass_q + 3'd1;
        end
        default: ;
      endcase

      if (abort && busy) begin
        for (int k = 0; k < DP_LAT; k++) begin
          pipe_v[k] <= 1'b0;
          pipe_a[k] <= '0;
        end
      end else begin
        pipe_v[0] <= issue_res;
        pipe_a[0] <= issue_waddr;
        for (int k = 1; k < DP_LAT; k++) begin
          pipe_v[k] <= pipe_v[k-1];
          pipe_a[k] <= pipe_a[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_poly_op_sequencer.sv
// Self-checking bench: a per-operation expected-output schedule built from the operation rules is
// compared with the sequencer every cycle, plus hand-computed spot checks at known cycles.
module tb_poly_op_sequencer;

  localparam int AW   = 8;
  localparam int W    = 32;
  localparam int NP   = 7;
  localparam int DL   = 3;
  localparam int MAXC = 400;

  logic          clk = 1'b0;
  logic          rst, start, add_or_sub, abort;
  logic [1:0]    mode;
  logic [AW-1:0] a_base, b_base, w_base;
  logic          rd_en, wr_en, dp_type, dp_pre_load, dp_load, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [1:0]    dp_mode;
  logic [2:0]    dp_stage;

  poly_op_sequencer #(.ADDR_W(AW), .WORDS(W), .NTT_PASSES(NP), .DP_LAT(DL)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .add_or_sub(add_or_sub),
    .a_base(a_base), .b_base(b_base), .w_base(w_base), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .dp_mode(dp_mode), .dp_stage(dp_stage), .dp_type(dp_type),
    .dp_pre_load(dp_pre_load), .dp_load(dp_load), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          pre, ld;
    logic [2:0]    stage;
    logic          typ;
    logic          chk_st, chk_pl;
    logic          busy, done;
  } exp_t;

  exp_t       sched [MAXC+1];
  int         total;
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         t0     = 0;
  int         t_start = 0;
  bit         active = 1'b0;
  bit         chk_en = 1'b0;
  logic [1:0] lmode  = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected per-cycle outputs of one operation, indexed by cycles after the start was accepted.
  task automatic build_sched(input logic [1:0] m, input logic aos,
                             input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] w);
    int k;
    for (int c = 0; c <= MAXC; c++) begin
      sched[c] = '0;
      sched[c].chk_pl = 1'b1;
    end
    if (m == 2'd3) begin
      total = 2 * W + DL + 1;
      for (int i = 0; i < W; i++) begin
        k = 2 * i + 1;
        sched[k].rd_en = 1; sched[k].rd_addr = AW'(a + i); sched[k].pre = 1;
        sched[k].stage = 0; sched[k].typ = aos; sched[k].chk_st = 1;
        sched[k+1].rd_en = 1; sched[k+1].rd_addr = AW'(b + i); sched[k+1].ld = 1;
        sched[k+1].stage = 1; sched[k+1].typ = aos; sched[k+1].chk_st = 1;
        sched[k+1+DL].wr_en = 1; sched[k+1+DL].wr_addr = AW'(w + i);
      end
    end else if (m == 2'd2) begin
      total = 4 * W + DL + 1;
      for (int i = 0; i < W; i++)
        for (int ph = 0; ph < 4; ph++) begin
          k = 4 * i + 1 + ph;
          sched[k].rd_en   = (ph < 2);
          sched[k].rd_addr = (ph == 0) ? AW'(a + i) : (ph == 1) ? AW'(b + i) : '0;
          sched[k].pre     = (ph == 0);
          sched[k].ld      = (ph == 1);
          sched[k].stage   = 3'(ph);
          sched[k].typ     = ph[0];
          sched[k].chk_st  = 1;
          if (ph == 3) begin
            sched[k+DL].wr_en = 1; sched[k+DL].wr_addr = AW'(w + i);
          end
        end
    end else begin
      total = NP * (W + DL) + 1;
      for (int p = 0; p < NP; p++)
        for (int j = 0; j < W; j++) begin
          k = p * (W + DL) + 1 + j;
          sched[k].rd_en   = 1;
          sched[k].rd_addr = AW'(((p == 0) ? a : w) + j);
          sched[k].stage   = 3'(p);
          sched[k].typ     = j[0];
          sched[k].chk_st  = 1;
          sched[k].chk_pl  = 0;
          sched[k+DL].wr_en = 1; sched[k+DL].wr_addr = AW'(w + j);
        end
    end
    for (int c = 1; c < total; c++) sched[c].busy = 1;
    sched[total].done = 1;
  endtask

  // Model of the handshake: accept in idle, finish after DONE, drop on abort or reset.
  always @(posedge clk) begin
    if (rst) begin
      active = 1'b0;
      lmode  = 2'd0;
    end else if (active) begin
      if ((cyc - t_start) == total || abort) active = 1'b0;
    end else if (start) begin
      active  = 1'b1;
      t_start = cyc;
      lmode   = mode;
      build_sched(mode, add_or_sub, a_base, b_base, w_base);
    end
    cyc++;
  end

  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (chk_en) begin
      k = cyc - t_start;
      e = '0;
      e.chk_st = 1;
      e.chk_pl = 1;
      if (active && k >= 0 && k <= total) e = sched[k];
      check("rd_en", rd_en, e.rd_en);
      check("rd_addr", rd_addr, e.rd_addr);
      check("wr_en", wr_en, e.wr_en);
      check("wr_addr", wr_addr, e.wr_addr);
      check("busy", busy, e.busy);
      check("done", done, e.done);
      check("dp_mode", dp_mode, lmode);
      if (e.chk_st) begin
        check("dp_stage", dp_stage, e.stage);
        check("dp_type", dp_type, e.typ);
      end
      if (e.chk_pl) begin
        check("dp_pre_load", dp_pre_load, e.pre);
        check("dp_load", dp_load, e.ld);
      end
    end
  end

  task automatic start_op(input logic [1:0] m, input logic aos, input logic [AW-1:0] a,
                          input logic [AW-1:0] b, input logic [AW-1:0] w, input logic with_abort);
    @(posedge clk); #1;
    start = 1'b1; mode = m; add_or_sub = aos; a_base = a; b_base = b; w_base = w; abort = with_abort;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic at_cycle(input int n);
    do @(negedge clk); while (cyc < t0 + n);
  endtask

  task automatic count_done(input int span, input string name);
    int n = 0;
    repeat (span) begin
      @(negedge clk);
      if (done) n++;
    end
    check(name, n, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; add_or_sub = 1'b0;
    a_base = '0; b_base = '0; w_base = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_en", rd_en, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_dp_mode", dp_mode, 0);
    @(posedge clk); #1 rst = 1'b0;

    // ADDSUB, a stray start at 10, then start held high into the following MULT.
    start_op(2'd3, 1'b1, 8'h10, 8'h40, 8'h80, 1'b0);
    at_cycle(1);  check("as_rd0", rd_addr, 8'h10); check("as_pre0", dp_pre_load, 1);
    at_cycle(2);  check("as_rd1", rd_addr, 8'h40); check("as_load1", dp_load, 1);
    at_cycle(5);  check("as_wr_en5", wr_en, 1); check("as_wr5", wr_addr, 8'h80);
    at_cycle(10); start = 1'b1;
    at_cycle(11); start = 1'b0;
    at_cycle(67); check("as_wr_last", wr_addr, 8'h9F);
    start = 1'b1; mode = 2'd2; add_or_sub = 1'b0; a_base = 8'h00; b_base = 8'h20; w_base = 8'h40;
    at_cycle(68); check("as_done", done, 1); check("as_busy_done", busy, 0);
    at_cycle(69); check("held_idle", busy, 0);
    t0 = t0 + 69;

    at_cycle(1);   check("mu_rd_en1", rd_en, 1); start = 1'b0;
    at_cycle(2);   check("mu_rd2", rd_addr, 8'h20);
    at_cycle(3);   check("mu_rd_en3", rd_en, 0);
    at_cycle(4);   check("mu_rd_en4", rd_en, 0);
    at_cycle(7);   check("mu_wr7", wr_addr, 8'h40); check("mu_wr_en7", wr_en, 1);
    at_cycle(11);  check("mu_wr11", wr_addr, 8'h41);
    at_cycle(132); check("mu_done", done, 1); check("mu_busy", busy, 0);

    // NTT pass boundary and completion.
    start_op(2'd0, 1'b0, 8'h00, 8'h00, 8'h20, 1'b0);
    at_cycle(1);   check("ntt_rd1", rd_addr, 8'h00);
    at_cycle(32);  check("ntt_rd32", rd_addr, 8'h1F);
    at_cycle(33);  check("ntt_drain", rd_en, 0);
    at_cycle(35);  check("ntt_wr35", wr_addr, 8'h3F);
    at_cycle(36);  check("ntt_rd36", rd_addr, 8'h20); check("ntt_stage36", dp_stage, 1);
    at_cycle(246); check("ntt_done", done, 1);

    // INTT aborted in pass 2.
    start_op(2'd1, 1'b0, 8'h00, 8'h00, 8'h20, 1'b0);
    at_cycle(100); check("ab_stage", dp_stage, 2); check("ab_busy100", busy, 1); abort = 1'b1;
    at_cycle(101); abort = 1'b0; check("ab_busy101", busy, 0); check("ab_wr101", wr_en, 0);
    count_done(160, "ab_no_done");

    // Reset in the middle of a MULT.
    start_op(2'd2, 1'b0, 8'h00, 8'h20, 8'h40, 1'b0);
    at_cycle(50); rst = 1'b1;
    at_cycle(51); rst = 1'b0; check("rst_busy", busy, 0); check("rst_wr", wr_en, 0);
    check("rst_mode", dp_mode, 0);
    count_done(150, "rst_no_done");

    // ADDSUB with start and abort together, result addresses wrapping past 0xFF.
    start_op(2'd3, 1'b0, 8'h00, 8'h40, 8'hF0, 1'b1);
    at_cycle(35); check("wrap_ff", wr_addr, 8'hFF);
    at_cycle(37); check("wrap_00", wr_addr, 8'h00); check("wrap_wr_en", wr_en, 1);
    at_cycle(68); check("wrap_done", done, 1);
    at_cycle(75);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
